// File: rtl/mem_wb_stage_if.sv
// Upstream (EX), data-memory, writeback and output-port signals of mem_wb_stage.
interface mem_wb_stage_if #(
  parameter int REG_BITS = 2
);
  logic                in_valid;
  logic                in_ready;
  logic [3:0]          in_op;
  logic [7:0]          in_result;
  logic [7:0]          in_addr;
  logic [REG_BITS-1:0] in_rd;
  logic                mem_req;
  logic                mem_we;
  logic [7:0]          mem_addr;
  logic [7:0]          mem_wdata;
  logic [7:0]          mem_rdata;
  logic                mem_ack;
  logic                wb_en;
  logic [REG_BITS-1:0] wb_rd;
  logic [7:0]          wb_data;
  logic [7:0]          out_port;
  logic                out_strobe;
  logic                mem_err;

  modport master (
    output in_valid, in_op, in_result, in_addr, in_rd, mem_rdata, mem_ack,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_en, wb_rd, wb_data, out_port, out_strobe, mem_err
  );

  modport slave (
    input  in_valid, in_op, in_result, in_addr, in_rd, mem_rdata, mem_ack,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output wb_en, wb_rd, wb_data, out_port, out_strobe, mem_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: register writeback, OUT port, LOAD/STORE over req/ack with timeout.
// Define MEM_WBUF_EN to retire STOREs into a one-entry background store buffer.
module mem_wb_stage #(
  parameter int REG_BITS    = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst_n,
  mem_wb_stage_if.slave bus
);
  localparam logic [3:0] OP_OUT    = 4'h6;
  localparam logic [3:0] OP_LOAD   = 4'hD;
  localparam logic [3:0] OP_STORE  = 4'hE;
  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  typedef enum logic {S_IDLE, S_MEM} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d, cnt_inc;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [REG_BITS-1:0] rd_q, rd_d;
  logic                wb_en_q, wb_en_d;
  logic [REG_BITS-1:0] wb_rd_q, wb_rd_d;
  logic [7:0]          wb_data_q, wb_data_d;
  logic [7:0]          out_q, out_d;
  logic                ostb_q, ostb_d;
  logic                err_q, err_d;
  logic                in_ready;
  logic                accept;

`ifdef MEM_WBUF_EN
  logic is_mem_op;
  assign is_mem_op = (bus.in_op == OP_LOAD) || (bus.in_op == OP_STORE);
  // A busy store buffer only blocks instructions that need the memory port.
  assign in_ready  = rst_n && (state_q == S_IDLE) && !(req_q && is_mem_op);
`else
  assign in_ready  = rst_n && (state_q == S_IDLE);
`endif

  assign accept  = bus.in_valid && in_ready;
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    out_d     = out_q;
    ostb_d    = 1'b0;
    err_d     = err_q;

    // Outstanding access: ack has priority over a timeout on the same edge.
    if (req_q) begin
      if (bus.mem_ack) begin
        req_d   = 1'b0;
        state_d = S_IDLE;
        if (!we_q) begin
          wb_en_d   = 1'b1;
          wb_rd_d   = rd_q;
          wb_data_d = bus.mem_rdata;
        end
      end else if (cnt_inc == TIMEOUT_C) begin
        req_d   = 1'b0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_inc;
      end
    end

    if (accept) begin
      case (bus.in_op)
        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'hF: begin
          wb_en_d   = 1'b1;
          wb_rd_d   = bus.in_rd;
          wb_data_d = bus.in_result;
        end
        OP_OUT: begin
          out_d  = bus.in_result;
          ostb_d = 1'b1;
        end
        OP_LOAD, OP_STORE: begin
          req_d   = 1'b1;
          we_d    = (bus.in_op == OP_STORE);
          addr_d  = bus.in_addr;
          wdata_d = bus.in_result;
          rd_d    = bus.in_rd;
          cnt_d   = 8'd0;
`ifdef MEM_WBUF_EN
          state_d = (bus.in_op == OP_LOAD) ? S_MEM : S_IDLE;
`else
          state_d = S_MEM;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 8'd0;
      wdata_q   <= 8'd0;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= 8'd0;
      out_q     <= 8'd0;
      ostb_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      out_q     <= out_d;
      ostb_q    <= ostb_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.mem_req    = req_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.wb_en      = wb_en_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.out_port   = out_q;
  assign bus.out_strobe = ostb_q;
  assign bus.mem_err    = err_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios followed by random transactions
// scored against a transaction-level model with its own view of memory contents.
module tb_mem_wb_stage;
  localparam int RB  = 2;
  localparam int TMO = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  logic [7:0] resp_mem [256];
  logic [7:0] ref_mem  [256];

  mem_wb_stage_if #(.REG_BITS(RB)) bus ();

  mem_wb_stage #(.REG_BITS(RB), .MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] res,
                       input logic [7:0] addr, input logic [RB-1:0] rd);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_result = res;
    bus.in_addr   = addr;
    bus.in_rd     = rd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},   32'(bus.in_ready),   0);
    chk({tag, "_mem_req"},    32'(bus.mem_req),    0);
    chk({tag, "_mem_we"},     32'(bus.mem_we),     0);
    chk({tag, "_mem_addr"},   32'(bus.mem_addr),   0);
    chk({tag, "_mem_wdata"},  32'(bus.mem_wdata),  0);
    chk({tag, "_wb_en"},      32'(bus.wb_en),      0);
    chk({tag, "_wb_rd"},      32'(bus.wb_rd),      0);
    chk({tag, "_wb_data"},    32'(bus.wb_data),    0);
    chk({tag, "_out_port"},   32'(bus.out_port),   0);
    chk({tag, "_out_strobe"}, 32'(bus.out_strobe), 0);
    chk({tag, "_mem_err"},    32'(bus.mem_err),    0);
  endtask

  initial begin
    logic [3:0]    op;
    logic [7:0]    res;
    logic [7:0]    addr;
    logic [RB-1:0] rd;
    int            lat;
    int            n;
    int            want_cycles;
    logic          wb_seen;
    logic          exp_err;
    logic [7:0]    exp_port;

    bus.in_valid  = 1'b0;
    bus.in_op     = 4'h0;
    bus.in_result = 8'h00;
    bus.in_addr   = 8'h00;
    bus.in_rd     = '0;
    bus.mem_rdata = 8'h00;
    bus.mem_ack   = 1'b0;
    for (int i = 0; i < 256; i++) begin
      resp_mem[i] = 8'($urandom);
      ref_mem[i]  = resp_mem[i];
    end

    // Reset state
    @(negedge clk);
    cyc();
    chk_all_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 32'(bus.in_ready), 1);

    // ADD and back-to-back SUB
    drive(4'h1, 8'h2A, 8'h00, 2'd2);
    cyc();
    chk("add_wb_en",   32'(bus.wb_en),    1);
    chk("add_wb_rd",   32'(bus.wb_rd),    2);
    chk("add_wb_data", 32'(bus.wb_data),  8'h2A);
    chk("add_ready",   32'(bus.in_ready), 1);
    drive(4'h2, 8'h11, 8'h00, 2'd3);
    cyc();
    chk("sub_wb_en",   32'(bus.wb_en),   1);
    chk("sub_wb_rd",   32'(bus.wb_rd),   3);
    chk("sub_wb_data", 32'(bus.wb_data), 8'h11);
    bus.in_valid = 1'b0;
    cyc();
    chk("wb_pulse_end", 32'(bus.wb_en), 0);

    // OUT
    drive(4'h6, 8'h81, 8'h00, 2'd0);
    cyc();
    bus.in_valid = 1'b0;
    chk("out_strobe",   32'(bus.out_strobe), 1);
    chk("out_port",     32'(bus.out_port),   8'h81);
    chk("out_no_wb",    32'(bus.wb_en),      0);
    cyc();
    chk("out_strobe_end", 32'(bus.out_strobe), 0);
    chk("out_port_hold",  32'(bus.out_port),   8'h81);

    // LOAD acknowledged in the third request cycle
    drive(4'hD, 8'h00, 8'h10, 2'd1);
    cyc();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("ld_req",   32'(bus.mem_req),  1);
      chk("ld_we",    32'(bus.mem_we),   0);
      chk("ld_addr",  32'(bus.mem_addr), 8'h10);
      chk("ld_ready", 32'(bus.in_ready), 0);
      if (k == 3) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'hC3;
      end
      cyc();
    end
    bus.mem_ack = 1'b0;
    chk("ld_wb_en",   32'(bus.wb_en),    1);
    chk("ld_wb_rd",   32'(bus.wb_rd),    1);
    chk("ld_wb_data", 32'(bus.wb_data),  8'hC3);
    chk("ld_req_off", 32'(bus.mem_req),  0);
    chk("ld_ready1",  32'(bus.in_ready), 1);
    cyc();
    chk("ld_wb_end", 32'(bus.wb_en), 0);

    // LOAD acknowledged on the timeout edge: ack wins
    drive(4'hD, 8'h00, 8'h20, 2'd3);
    cyc();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      chk("tle_req", 32'(bus.mem_req), 1);
      if (k == TMO) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h5A;
      end
      cyc();
    end
    bus.mem_ack = 1'b0;
    chk("tle_wb_en",   32'(bus.wb_en),   1);
    chk("tle_wb_rd",   32'(bus.wb_rd),   3);
    chk("tle_wb_data", 32'(bus.wb_data), 8'h5A);
    chk("tle_err",     32'(bus.mem_err), 0);
    chk("tle_req_off", 32'(bus.mem_req), 0);

    // STORE that never gets an ack
    drive(4'hE, 8'h55, 8'hF0, 2'd0);
    cyc();
    bus.in_valid = 1'b0;
    chk("st_we",    32'(bus.mem_we),    1);
    chk("st_wdata", 32'(bus.mem_wdata), 8'h55);
    chk("st_addr",  32'(bus.mem_addr),  8'hF0);
    n = 0;
    wb_seen = 1'b0;
    while (bus.mem_req && n < 40) begin
      n++;
      if (bus.wb_en) wb_seen = 1'b1;
      cyc();
    end
    if (bus.wb_en) wb_seen = 1'b1;
    chk("st_to_cycles", 32'(n),            TMO);
    chk("st_to_no_wb",  32'(wb_seen),      0);
    chk("st_to_err",    32'(bus.mem_err),  1);
    chk("st_to_ready",  32'(bus.in_ready), 1);
    repeat (3) cyc();
    chk("st_err_sticky", 32'(bus.mem_err), 1);

    // Reset in the middle of a LOAD
    drive(4'hD, 8'h00, 8'h33, 2'd2);
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk("rm_req", 32'(bus.mem_req), 1);
    rst_n = 1'b0;
    #1;
    chk("rm_ready_low", 32'(bus.in_ready), 0);
    cyc();
    chk_all_zero("rm");
    rst_n = 1'b1;
    #1;
    chk("rm_ready_high", 32'(bus.in_ready), 1);

    // Random transactions against the model
    exp_err  = 1'b0;
    exp_port = 8'h00;
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid  = 1'b0;
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = 8'($urandom);
        cyc();
        bus.mem_ack = 1'b0;
        chk("idle_no_wb",  32'(bus.wb_en),   0);
        chk("idle_no_req", 32'(bus.mem_req), 0);
      end
      op   = 4'($urandom_range(0, 15));
      res  = 8'($urandom);
      addr = 8'($urandom_range(0, 7));
      rd   = RB'($urandom_range(0, 3));
      lat  = $urandom_range(1, 18);
      chk("r_ready", 32'(bus.in_ready), 1);
      drive(op, res, addr, rd);
      cyc();
      bus.in_valid = 1'b0;
      if (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'hF}) begin
        chk("r_wb_en",   32'(bus.wb_en),      1);
        chk("r_wb_rd",   32'(bus.wb_rd),      32'(rd));
        chk("r_wb_data", 32'(bus.wb_data),    32'(res));
        chk("r_no_strb", 32'(bus.out_strobe), 0);
      end else if (op == 4'h6) begin
        exp_port = res;
        chk("r_strobe", 32'(bus.out_strobe), 1);
        chk("r_out_wb", 32'(bus.wb_en),      0);
      end else if (op == 4'hD || op == 4'hE) begin
        want_cycles = (lat <= TMO) ? lat : TMO;
        n = 0;
        while (bus.mem_req && n < 40) begin
          n++;
          chk("r_m_addr",  32'(bus.mem_addr), 32'(addr));
          chk("r_m_we",    32'(bus.mem_we),   32'(op == 4'hE));
          chk("r_m_ready", 32'(bus.in_ready), 0);
          if (op == 4'hE) chk("r_m_wdata", 32'(bus.mem_wdata), 32'(res));
          if (n == lat) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = resp_mem[bus.mem_addr];
            if (bus.mem_we) resp_mem[bus.mem_addr] = bus.mem_wdata;
          end
          cyc();
          bus.mem_ack = 1'b0;
        end
        chk("r_m_cycles", 32'(n), 32'(want_cycles));
        if (lat <= TMO && op == 4'hD) begin
          chk("r_ld_wb_en",   32'(bus.wb_en),   1);
          chk("r_ld_wb_rd",   32'(bus.wb_rd),   32'(rd));
          chk("r_ld_wb_data", 32'(bus.wb_data), 32'(ref_mem[addr]));
        end else begin
          chk("r_m_no_wb", 32'(bus.wb_en), 0);
        end
        if (lat <= TMO && op == 4'hE) ref_mem[addr] = res;
        if (lat > TMO) exp_err = 1'b1;
      end else begin
        chk("r_nop_wb",   32'(bus.wb_en),      0);
        chk("r_nop_strb", 32'(bus.out_strobe), 0);
      end
      chk("r_out_port", 32'(bus.out_port), 32'(exp_port));
      chk("r_err",      32'(bus.mem_err),  32'(exp_err));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory/writeback stage directly downstream of the EX-stage ALU.
- Consumes the ALU's 4-bit op and 8-bit result, plus the destination register index and memory address.
- Performs data-memory LOAD/STORE over a req/ack handshake, drives the OUT port, and issues register-file writeback.
- Stalls upstream via in_ready while a memory access is outstanding.

Parameters:
- REG_BITS, 2, width of destination register index (4 GPRs).
- MEM_TIMEOUT, 15, cycles in MEM without mem_ack before the access is aborted (1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  EX stage presents an instruction.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
- in_op  in  4  opcode: 1 ADD, 2 SUB, 3 NAND, 4 SHL, 5 SHR, 6 OUT, 7 IN, 8 MOV, D LOAD, E STORE, F LOADIMM.
- in_result  in  8  ALU result; store data for STORE.
- in_addr  in  8  memory address for LOAD/STORE.
- in_rd  in  REG_BITS  destination register.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  8  memory address.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- wb_en  out  1  one-cycle register-file write strobe.
- wb_rd  out  REG_BITS  writeback register.
- wb_data  out  8  writeback data.
- out_port  out  8  latched output port.
- out_strobe  out  1  one-cycle pulse when out_port updates.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State IDLE; timeout counter 0.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_rd, wb_data, out_port, out_strobe, mem_err.
  - in_ready is 0 while rst_n=0.
  - A reset during MEM abandons the access; mem_req is 0 after that edge.
- States:
  - IDLE: in_ready=1.
  - MEM: in_ready=0.
- IDLE accept, register-writing ops (1,2,3,4,5,7,8,F):
  - Next cycle: wb_en=1, wb_rd=in_rd, wb_data=in_result.
  - Stay IDLE. Latency 1, throughput 1 per cycle.
- IDLE accept, OUT (6):
  - Next cycle: out_port=in_result, out_strobe=1.
  - No writeback.
- IDLE accept, ops 0, 9, A, B, C: consumed, no effect.
- IDLE accept, LOAD (D) or STORE (E):
  - Latch in_addr, in_result and in_rd.
  - Enter MEM; from the next cycle drive mem_req=1, mem_we=(op==E), mem_addr, mem_wdata.
  - Hold all of these stable until completion.
- MEM on mem_ack=1:
  - Drop mem_req next cycle; return to IDLE (accepting again from that cycle).
  - LOAD: next cycle wb_en=1, wb_rd=latched rd, wb_data=mem_rdata sampled on the ack edge.
  - STORE: no writeback.
- MEM without ack:
  - Counter increments each cycle.
  - When the counter equals MEM_TIMEOUT: abort, mem_req=0, mem_err=1, no writeback, return to IDLE.
  - Ack and timeout on the same edge: ack wins, mem_err unchanged.
- Counter clears on entering MEM.
- mem_ack in IDLE is ignored.
- mem_err clears only on reset.
- wb_en and out_strobe are pulses: 0 in any cycle not described above.
- in_ready is combinational from state and rst_n; no combinational path from in_valid to in_ready.

Optional Feature:
- Macro: MEM_WBUF_EN.
- With MEM_WBUF_EN defined: one-entry store buffer.
  - A STORE accepted while the buffer is empty is retired immediately; in_ready stays 1.
  - The buffer runs the mem handshake in the background while non-memory ops continue.
  - A LOAD or STORE arriving while the buffer is busy sees in_ready=0 until that buffered store completes.
  - LOAD behaviour is otherwise unchanged.
  - Timeout on a buffered store sets mem_err and frees the buffer.
- Without MEM_WBUF_EN: STORE blocks in MEM exactly as described under Behaviour.

Test Plan:
- ADD with in_result=8'h2A, in_rd=2 -> next cycle wb_en=1, wb_rd=2, wb_data=8'h2A; in_ready stays 1; back-to-back ops give wb_en on consecutive cycles.
- OUT with in_result=8'h81 -> out_strobe pulses 1 cycle, out_port=8'h81 and holds; wb_en stays 0.
- LOAD in_addr=8'h10, in_rd=1; memory acks 3 cycles after mem_req with rdata=8'hC3 -> mem_req/mem_we=0/mem_addr=8'h10 stable until ack; in_ready=0 throughout; wb_en next cycle with data 8'hC3 to r1.
- STORE in_result=8'h55, in_addr=8'hF0, ack never arrives -> mem_req drops after 15 cycles; mem_err=1 sticky; no wb_en; in_ready=1 afterwards.
- LOAD with ack on the exact timeout edge -> writeback occurs, mem_err stays 0. rst_n low during MEM -> mem_req=0 and all outputs 0 after that edge, with mem_err cleared.
